// File: rtl/gl_matrix_stack_if.sv
// gl_matrix_stack_if: command, load-row and top/status bus for the GL matrix stack
interface gl_matrix_stack_if #(
  parameter int MV_DEPTH = 32,
  parameter int PJ_DEPTH = 4
);
  logic matrix_mode;
  logic push_en;
  logic pop_en;
  logic load_id_en;
  logic load_en;
  logic [31:0] load_row_0;
  logic [31:0] load_row_1;
  logic [31:0] load_row_2;
  logic [31:0] load_row_3;
  logic mul_wr_en;
  logic [511:0] mul_wr_data;
  logic [511:0] top_modelview;
  logic [511:0] top_projection;
  logic [$clog2(MV_DEPTH):0] mv_depth;
  logic [$clog2(PJ_DEPTH):0] pj_depth;
  logic overflow;
  logic underflow;
  logic busy;
  modport master (
    output matrix_mode, push_en, pop_en, load_id_en, load_en,
    output load_row_0, load_row_1, load_row_2, load_row_3, mul_wr_en, mul_wr_data,
    input top_modelview, top_projection, mv_depth, pj_depth, overflow, underflow, busy
  );
  modport slave (
    input matrix_mode, push_en, pop_en, load_id_en, load_en,
    input load_row_0, load_row_1, load_row_2, load_row_3, mul_wr_en, mul_wr_data,
    output top_modelview, top_projection, mv_depth, pj_depth, overflow, underflow, busy
  );
endinterface

// File: rtl/gl_matrix_stack.sv
// gl_matrix_stack: modelview/projection matrix stacks with push/pop/identity/load/multiply-writeback
module gl_matrix_stack #(
  parameter int MV_DEPTH = 32,
  parameter int PJ_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  gl_matrix_stack_if.slave bus
);
  localparam int MW = $clog2(MV_DEPTH) + 1;
  localparam int PW = $clog2(PJ_DEPTH) + 1;
  localparam int MA = MW - 1;
  localparam int PA = PW - 1;
  localparam logic [31:0] ONE = 32'h3F800000;
  localparam logic [31:0] ZERO = 32'h00000000;
  localparam logic [511:0] IDENT = {ONE, {4{ZERO}}, ONE, {4{ZERO}}, ONE, {4{ZERO}}, ONE};
  typedef enum logic {IDLE, LOAD} state_t;
  state_t state_q, state_d;
  logic [511:0] mv_top, pj_top;
  logic [511:0] mv_mem [MV_DEPTH];
  logic [511:0] pj_mem [PJ_DEPTH];
  logic [MW-1:0] mv_depth_q;
  logic [PW-1:0] pj_depth_q;
  logic [MA-1:0] mv_wi, mv_ri;
  logic [PA-1:0] pj_wi, pj_ri;
  logic [1:0] beat;
  logic [127:0] row;
  logic push_q, pop_q, lid_q, ovf, unf, busy_q, load_mode;
  logic idle, mode, push_e, pop_e, lid_e;
  logic do_mul, do_pop, do_push, do_lid, do_load;
  logic mv_full, mv_empty, pj_full, pj_empty;
  assign idle = state_q == IDLE;
  assign mode = bus.matrix_mode;
  assign push_e = bus.push_en & ~push_q;
  assign pop_e = bus.pop_en & ~pop_q;
  assign lid_e = bus.load_id_en & ~lid_q;
  assign do_mul = idle & bus.mul_wr_en;
  assign do_pop = idle & ~bus.mul_wr_en & pop_e;
  assign do_push = idle & ~bus.mul_wr_en & ~pop_e & push_e;
  assign do_lid = idle & ~bus.mul_wr_en & ~pop_e & ~push_e & lid_e;
  assign do_load = idle & ~bus.mul_wr_en & ~pop_e & ~push_e & ~lid_e & bus.load_en;
  assign mv_full = mv_depth_q == MW'(MV_DEPTH - 1);
  assign pj_full = pj_depth_q == PW'(PJ_DEPTH - 1);
  assign mv_empty = mv_depth_q == '0;
  assign pj_empty = pj_depth_q == '0;
  assign mv_wi = mv_depth_q[MA-1:0];
  assign pj_wi = pj_depth_q[PA-1:0];
  assign mv_ri = mv_wi - MA'(1);
  assign pj_ri = pj_wi - PA'(1);
  assign row = {bus.load_row_3, bus.load_row_2, bus.load_row_1, bus.load_row_0};
  always_comb begin
    state_d = idle ? (do_load ? LOAD : IDLE) : (beat == 2'd3 ? IDLE : LOAD);
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
  end
  always_ff @(posedge clk) begin
    if (!rst && do_push && mode && !mv_full) mv_mem[mv_wi] <= mv_top;
    if (!rst && do_push && !mode && !pj_full) pj_mem[pj_wi] <= pj_top;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mv_top <= IDENT;
      pj_top <= IDENT;
      mv_depth_q <= '0;
      pj_depth_q <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      busy_q <= 1'b0;
      beat <= 2'd0;
      push_q <= 1'b0;
      pop_q <= 1'b0;
      lid_q <= 1'b0;
      load_mode <= 1'b0;
    end else begin
      push_q <= bus.push_en;
      pop_q <= bus.pop_en;
      lid_q <= bus.load_id_en;
      if (do_mul) begin
        if (mode) mv_top <= bus.mul_wr_data;
        else pj_top <= bus.mul_wr_data;
      end
      if (do_pop) begin
        if (mode) begin
          if (mv_empty) unf <= 1'b1;
          else begin
            mv_top <= mv_mem[mv_ri];
            mv_depth_q <= mv_depth_q - MW'(1);
          end
        end else begin
          if (pj_empty) unf <= 1'b1;
          else begin
            pj_top <= pj_mem[pj_ri];
            pj_depth_q <= pj_depth_q - PW'(1);
          end
        end
      end
      if (do_push) begin
        if (mode) begin
          if (mv_full) ovf <= 1'b1;
          else mv_depth_q <= mv_depth_q + MW'(1);
        end else begin
          if (pj_full) ovf <= 1'b1;
          else pj_depth_q <= pj_depth_q + PW'(1);
        end
      end
      if (do_lid) begin
        if (mode) mv_top <= IDENT;
        else pj_top <= IDENT;
      end
      if (do_load) begin
        load_mode <= mode;
        busy_q <= 1'b1;
        beat <= 2'd0;
      end
      if (!idle) begin
        if (load_mode) mv_top[{beat, 7'd0} +: 128] <= row;
        else pj_top[{beat, 7'd0} +: 128] <= row;
        beat <= beat + 2'd1;
        if (beat == 2'd3) busy_q <= 1'b0;
      end
    end
  end
  assign bus.top_modelview = mv_top;
  assign bus.top_projection = pj_top;
  assign bus.mv_depth = mv_depth_q;
  assign bus.pj_depth = pj_depth_q;
  assign bus.overflow = ovf;
  assign bus.underflow = unf;
  assign bus.busy = busy_q;
endmodule
